// File: rtl/mseq_pkg.sv
// Shared opcode and next-address source encodings for the microsequencer and its bench.
package mseq_pkg;

    localparam int MSEQ_OPCODE_W = 4;
    localparam int MSEQ_SRC_W    = 3;

    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_ENC     = 4'b0000;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_FETCH   = 4'b0001;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_BRANCH  = 4'b0010;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_INC     = 4'b0011;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_ENC_IF  = 4'b0100;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_FETCH_IF= 4'b0101;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_INC_IF  = 4'b0110;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_WAIT    = 4'b0111;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_CALL    = 4'b1000;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_RET     = 4'b1001;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_CALL_IF = 4'b1010;
    localparam logic [MSEQ_OPCODE_W-1:0] MSEQ_OP_RET_IF  = 4'b1011;

    localparam logic [MSEQ_SRC_W-1:0] MSEQ_SRC_ENC    = 3'd0;
    localparam logic [MSEQ_SRC_W-1:0] MSEQ_SRC_FETCH  = 3'd1;
    localparam logic [MSEQ_SRC_W-1:0] MSEQ_SRC_BRANCH = 3'd2;
    localparam logic [MSEQ_SRC_W-1:0] MSEQ_SRC_INC    = 3'd3;
    localparam logic [MSEQ_SRC_W-1:0] MSEQ_SRC_HOLD   = 3'd4;
    localparam logic [MSEQ_SRC_W-1:0] MSEQ_SRC_POP    = 3'd5;

endpackage

// File: rtl/mseq_return_stack.sv
// LIFO holding subroutine return addresses; pushes when full and pops when empty are ignored
// here, the caller flags them.
module mseq_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign wr_idx   = level_q[PTR_W-1:0];
    assign rd_idx   = PTR_W'(level_q - 1'b1);
    assign top_data = mem_q[rd_idx];

    always_comb begin
        level_d = level_q;
        mem_d   = mem_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            level_d       = level_q + 1'b1;
        end else if (pop && !empty) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Entry contents need no reset: the level alone says which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/microsequencer_next_address.sv
// Control-unit microsequencer: picks and registers the next control-store address.
// Return stack and its error flag exist only when MSEQ_RETURN_STACK_EN is defined.
module microsequencer_next_address
    import mseq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int COND_N      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int FETCH_ADDR  = 1,
    parameter int RESET_ADDR  = 0
) (
    input  logic                         Clock,
    input  logic                         Reset_N,
    input  logic                         Stall,
    input  logic [3:0]                   Next_State_Control,
    input  logic [$clog2(COND_N)-1:0]    Cond_Select,
    input  logic                         Invert_Control,
    input  logic [COND_N-1:0]            Conditions,
    input  logic [ADDR_W-1:0]            Encoder_Address,
    input  logic [ADDR_W-1:0]            Branch_Address,
    output logic [ADDR_W-1:0]            State_Address,
    output logic [2:0]                   Next_Address_Select,
    output logic [$clog2(STACK_DEPTH):0] Stack_Level,
    output logic                         Stack_Error
);

    localparam int SEL_W = $clog2(COND_N);

    logic [(1<<SEL_W)-1:0] cond_ext;
    logic                  cond;
    logic [MSEQ_SRC_W-1:0] src;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     inc_addr;

`ifdef MSEQ_RETURN_STACK_EN
    logic              push_req;
    logic              pop_req;
    logic              stack_full;
    logic              stack_empty;
    logic [ADDR_W-1:0] stack_top;
    logic              err_q, err_d;
`endif

    // Unpopulated select codes read as a zero condition before inversion.
    always_comb begin
        cond_ext                 = '0;
        cond_ext[COND_N-1:0]     = Conditions;
    end

    assign cond     = cond_ext[Cond_Select] ^ Invert_Control;
    assign inc_addr = addr_q + 1'b1;

    always_comb begin
        src = MSEQ_SRC_FETCH;
`ifdef MSEQ_RETURN_STACK_EN
        push_req = 1'b0;
        pop_req  = 1'b0;
`endif
        case (Next_State_Control)
            MSEQ_OP_ENC:      src = MSEQ_SRC_ENC;
            MSEQ_OP_FETCH:    src = MSEQ_SRC_FETCH;
            MSEQ_OP_BRANCH:   src = MSEQ_SRC_BRANCH;
            MSEQ_OP_INC:      src = MSEQ_SRC_INC;
            MSEQ_OP_ENC_IF:   src = cond ? MSEQ_SRC_ENC   : MSEQ_SRC_BRANCH;
            MSEQ_OP_FETCH_IF: src = cond ? MSEQ_SRC_FETCH : MSEQ_SRC_BRANCH;
            MSEQ_OP_INC_IF:   src = cond ? MSEQ_SRC_INC   : MSEQ_SRC_BRANCH;
            MSEQ_OP_WAIT:     src = cond ? MSEQ_SRC_INC   : MSEQ_SRC_HOLD;
`ifdef MSEQ_RETURN_STACK_EN
            MSEQ_OP_CALL: begin
                src      = MSEQ_SRC_BRANCH;
                push_req = 1'b1;
            end
            MSEQ_OP_RET: begin
                src     = MSEQ_SRC_POP;
                pop_req = 1'b1;
            end
            MSEQ_OP_CALL_IF: begin
                src      = cond ? MSEQ_SRC_BRANCH : MSEQ_SRC_INC;
                push_req = cond;
            end
            MSEQ_OP_RET_IF: begin
                src     = cond ? MSEQ_SRC_POP : MSEQ_SRC_INC;
                pop_req = cond;
            end
`else
            MSEQ_OP_CALL:     src = MSEQ_SRC_BRANCH;
            MSEQ_OP_RET:      src = MSEQ_SRC_FETCH;
            MSEQ_OP_CALL_IF:  src = cond ? MSEQ_SRC_BRANCH : MSEQ_SRC_INC;
            MSEQ_OP_RET_IF:   src = cond ? MSEQ_SRC_FETCH  : MSEQ_SRC_INC;
`endif
            default:          src = MSEQ_SRC_FETCH;
        endcase
    end

    // A return with nothing on the stack falls back to the fetch state.
    always_comb begin
        addr_d = addr_q;
        if (!Stall) begin
            case (src)
                MSEQ_SRC_ENC:    addr_d = Encoder_Address;
                MSEQ_SRC_FETCH:  addr_d = ADDR_W'(FETCH_ADDR);
                MSEQ_SRC_BRANCH: addr_d = Branch_Address;
                MSEQ_SRC_INC:    addr_d = inc_addr;
                MSEQ_SRC_HOLD:   addr_d = addr_q;
`ifdef MSEQ_RETURN_STACK_EN
                MSEQ_SRC_POP:    addr_d = stack_empty ? ADDR_W'(FETCH_ADDR) : stack_top;
`endif
                default:         addr_d = ADDR_W'(FETCH_ADDR);
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            addr_q <= ADDR_W'(RESET_ADDR);
        end else begin
            addr_q <= addr_d;
        end
    end

    assign State_Address       = addr_q;
    assign Next_Address_Select = src;

`ifdef MSEQ_RETURN_STACK_EN
    mseq_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk       (Clock),
        .rst_n     (Reset_N),
        .push      (push_req && !Stall),
        .pop       (pop_req && !Stall),
        .push_data (inc_addr),
        .top_data  (stack_top),
        .level     (Stack_Level),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        err_d = err_q;
        if (!Stall && ((push_req && stack_full) || (pop_req && stack_empty))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Stack_Error = err_q;
`else
    assign Stack_Level = '0;
    assign Stack_Error = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer_next_address.sv
// Scoreboard bench for microsequencer_next_address; expectations follow MSEQ_RETURN_STACK_EN.
module tb_microsequencer_next_address;
    import mseq_pkg::*;

`ifdef MSEQ_RETURN_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset_N;
    logic       Stall;
    logic [3:0] Next_State_Control;
    logic [1:0] Cond_Select;
    logic       Invert_Control;
    logic [3:0] Conditions;
    logic [7:0] Encoder_Address;
    logic [7:0] Branch_Address;
    logic [7:0] State_Address;
    logic [2:0] Next_Address_Select;
    logic [2:0] Stack_Level;
    logic       Stack_Error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] op;
        logic [1:0] csel;
        logic       inv;
        logic [3:0] cond;
        logic [7:0] enc;
        logic [7:0] br;
        logic       stall;
        logic [2:0] sel;
        logic [7:0] addr;
        logic [2:0] lvl;
        logic       err;
    } step_t;

    step_t sb[$];

    microsequencer_next_address dut (
        .Clock               (Clock),
        .Reset_N             (Reset_N),
        .Stall               (Stall),
        .Next_State_Control  (Next_State_Control),
        .Cond_Select         (Cond_Select),
        .Invert_Control      (Invert_Control),
        .Conditions          (Conditions),
        .Encoder_Address     (Encoder_Address),
        .Branch_Address      (Branch_Address),
        .State_Address       (State_Address),
        .Next_Address_Select (Next_Address_Select),
        .Stack_Level         (Stack_Level),
        .Stack_Error         (Stack_Error)
    );

    always #5 Clock = ~Clock;

    function automatic step_t mk(input logic [3:0] op, input logic [1:0] csel, input logic inv,
                                 input logic [3:0] cond, input logic [7:0] enc, input logic [7:0] br,
                                 input logic stall, input logic [2:0] sel, input logic [7:0] addr,
                                 input logic [2:0] lvl, input logic err);
        step_t s;
        s.op = op; s.csel = csel; s.inv = inv; s.cond = cond; s.enc = enc; s.br = br;
        s.stall = stall; s.sel = sel; s.addr = addr; s.lvl = lvl; s.err = err;
        return s;
    endfunction

    // Drives one cycle of inputs and lets the combinational select settle.
    task automatic apply(input step_t s);
        Next_State_Control = s.op;
        Cond_Select        = s.csel;
        Invert_Control     = s.inv;
        Conditions         = s.cond;
        Encoder_Address    = s.enc;
        Branch_Address     = s.br;
        Stall              = s.stall;
        #1;
    endtask

    task automatic test_reset();
        Reset_N = 1'b1;
        apply(mk(MSEQ_OP_INC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 Reset_N = 1'b0;
        #1;
        checks++;
        if (State_Address !== 8'h00) begin
            errors++; $display("[TB] FAIL reset addr: got %h expected 00", State_Address);
        end
        checks++;
        if (Stack_Level !== 3'd0 || Stack_Error !== 1'b0) begin
            errors++; $display("[TB] FAIL reset stack: got lvl=%0d err=%b expected lvl=0 err=0", Stack_Level, Stack_Error);
        end
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (State_Address !== 8'h00) begin
            errors++; $display("[TB] FAIL reset hold addr: got %h expected 00", State_Address);
        end
        @(negedge Clock);
        Reset_N = 1'b1;
    endtask

    task automatic test_sequencing();
        step_t st[$];
        step_t e;
        st.push_back(mk(MSEQ_OP_ENC,    0, 0, 0, 8'hFF, 0,     0, MSEQ_SRC_ENC,    8'hFF, 0, 0));
        st.push_back(mk(MSEQ_OP_INC,    0, 0, 0, 0,     0,     0, MSEQ_SRC_INC,    8'h00, 0, 0));
        st.push_back(mk(MSEQ_OP_FETCH,  0, 0, 0, 0,     0,     0, MSEQ_SRC_FETCH,  8'h01, 0, 0));
        st.push_back(mk(MSEQ_OP_ENC,    0, 0, 0, 8'h40, 0,     0, MSEQ_SRC_ENC,    8'h40, 0, 0));
        st.push_back(mk(4'b1100,        0, 0, 0, 8'h40, 8'h9A, 0, MSEQ_SRC_FETCH,  8'h01, 0, 0));
        st.push_back(mk(MSEQ_OP_BRANCH, 0, 0, 0, 0,     8'h9A, 0, MSEQ_SRC_BRANCH, 8'h9A, 0, 0));
        st.push_back(mk(4'b1111,        0, 0, 0, 0,     8'h9A, 0, MSEQ_SRC_FETCH,  8'h01, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            checks++;
            if (Next_Address_Select !== st[i].sel) begin
                errors++; $display("[TB] FAIL seq[%0d] sel: got %0d expected %0d", i, Next_Address_Select, st[i].sel);
            end
            sb.push_back(st[i]);
            @(posedge Clock); #1;
            e = sb.pop_front();
            checks++;
            if (State_Address !== e.addr) begin
                errors++; $display("[TB] FAIL seq[%0d] addr: got %h expected %h", i, State_Address, e.addr);
            end
            checks++;
            if (Stack_Level !== e.lvl || Stack_Error !== e.err) begin
                errors++; $display("[TB] FAIL seq[%0d] stack: got lvl=%0d err=%b expected lvl=%0d err=%b", i, Stack_Level, Stack_Error, e.lvl, e.err);
            end
        end
    endtask

    task automatic test_wait();
        step_t st[$];
        step_t e;
        st.push_back(mk(MSEQ_OP_ENC, 0, 0, 0, 8'h20, 0, 0, MSEQ_SRC_ENC, 8'h20, 0, 0));
        for (int k = 0; k < 3; k++)
            st.push_back(mk(MSEQ_OP_WAIT, 2'd1, 0, 4'b1101, 0, 8'hEE, 0, MSEQ_SRC_HOLD, 8'h20, 0, 0));
        st.push_back(mk(MSEQ_OP_WAIT, 2'd1, 0, 4'b0010, 0, 8'hEE, 0, MSEQ_SRC_INC, 8'h21, 0, 0));
        st.push_back(mk(MSEQ_OP_WAIT, 2'd1, 1, 4'b0000, 0, 8'hEE, 0, MSEQ_SRC_INC, 8'h22, 0, 0));
        st.push_back(mk(MSEQ_OP_WAIT, 2'd1, 1, 4'b0010, 0, 8'hEE, 0, MSEQ_SRC_HOLD, 8'h22, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            checks++;
            if (Next_Address_Select !== st[i].sel) begin
                errors++; $display("[TB] FAIL wait[%0d] sel: got %0d expected %0d", i, Next_Address_Select, st[i].sel);
            end
            sb.push_back(st[i]);
            @(posedge Clock); #1;
            e = sb.pop_front();
            checks++;
            if (State_Address !== e.addr) begin
                errors++; $display("[TB] FAIL wait[%0d] addr: got %h expected %h", i, State_Address, e.addr);
            end
        end
    endtask

    task automatic test_call_ret();
        step_t st[$];
        step_t e;
        st.push_back(mk(MSEQ_OP_ENC,  0, 0, 0, 8'h10, 0,     0, MSEQ_SRC_ENC,    8'h10, 0, 0));
        st.push_back(mk(MSEQ_OP_CALL, 0, 0, 0, 0,     8'h80, 0, MSEQ_SRC_BRANCH, 8'h80, STK ? 3'd1 : 3'd0, 0));
        st.push_back(mk(MSEQ_OP_RET,  0, 0, 0, 0,     8'h80, 0, STK ? MSEQ_SRC_POP : MSEQ_SRC_FETCH,
                        STK ? 8'h11 : 8'h01, 0, 0));
        st.push_back(mk(MSEQ_OP_ENC,      0, 0, 0,       8'h30, 0,     0, MSEQ_SRC_ENC,    8'h30, 0, 0));
        st.push_back(mk(MSEQ_OP_INC_IF,   0, 0, 4'b0001, 0,     8'h55, 0, MSEQ_SRC_INC,    8'h31, 0, 0));
        st.push_back(mk(MSEQ_OP_INC_IF,   0, 1, 4'b0001, 0,     8'h55, 0, MSEQ_SRC_BRANCH, 8'h55, 0, 0));
        st.push_back(mk(MSEQ_OP_ENC_IF,   3, 0, 4'b1000, 8'h66, 8'h77, 0, MSEQ_SRC_ENC,    8'h66, 0, 0));
        st.push_back(mk(MSEQ_OP_FETCH_IF, 3, 0, 4'b0111, 8'h66, 8'h77, 0, MSEQ_SRC_BRANCH, 8'h77, 0, 0));
        st.push_back(mk(MSEQ_OP_CALL_IF,  2, 0, 4'b0100, 0,     8'hA0, 0, MSEQ_SRC_BRANCH, 8'hA0, STK ? 3'd1 : 3'd0, 0));
        st.push_back(mk(MSEQ_OP_RET_IF,   2, 0, 4'b0000, 0,     8'hA0, 0, MSEQ_SRC_INC,    8'hA1, STK ? 3'd1 : 3'd0, 0));
        st.push_back(mk(MSEQ_OP_RET_IF,   2, 0, 4'b0100, 0,     8'hA0, 0, STK ? MSEQ_SRC_POP : MSEQ_SRC_FETCH,
                        STK ? 8'h78 : 8'h01, 0, 0));
        st.push_back(mk(MSEQ_OP_CALL_IF,  2, 1, 4'b0100, 0,     8'hA0, 0, MSEQ_SRC_INC,
                        STK ? 8'h79 : 8'h02, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            checks++;
            if (Next_Address_Select !== st[i].sel) begin
                errors++; $display("[TB] FAIL call[%0d] sel: got %0d expected %0d", i, Next_Address_Select, st[i].sel);
            end
            sb.push_back(st[i]);
            @(posedge Clock); #1;
            e = sb.pop_front();
            checks++;
            if (State_Address !== e.addr) begin
                errors++; $display("[TB] FAIL call[%0d] addr: got %h expected %h", i, State_Address, e.addr);
            end
            checks++;
            if (Stack_Level !== e.lvl || Stack_Error !== e.err) begin
                errors++; $display("[TB] FAIL call[%0d] stack: got lvl=%0d err=%b expected lvl=%0d err=%b", i, Stack_Level, Stack_Error, e.lvl, e.err);
            end
        end
    endtask

    task automatic test_overflow();
        step_t st[$];
        step_t e;
        st.push_back(mk(MSEQ_OP_ENC, 0, 0, 0, 8'h10, 0, 0, MSEQ_SRC_ENC, 8'h10, 0, 0));
        for (int k = 1; k <= 5; k++)
            st.push_back(mk(MSEQ_OP_CALL, 0, 0, 0, 0, 8'h80, 0, MSEQ_SRC_BRANCH, 8'h80,
                            STK ? 3'((k > 4) ? 4 : k) : 3'd0, STK && (k == 5)));
        for (int k = 1; k <= 4; k++)
            st.push_back(mk(MSEQ_OP_RET, 0, 0, 0, 0, 8'h80, 0, STK ? MSEQ_SRC_POP : MSEQ_SRC_FETCH,
                            STK ? ((k == 4) ? 8'h11 : 8'h81) : 8'h01, STK ? 3'(4 - k) : 3'd0, STK));
        st.push_back(mk(MSEQ_OP_RET, 0, 0, 0, 0, 8'h80, 0, STK ? MSEQ_SRC_POP : MSEQ_SRC_FETCH,
                        8'h01, 0, STK));
        foreach (st[i]) begin
            apply(st[i]);
            checks++;
            if (Next_Address_Select !== st[i].sel) begin
                errors++; $display("[TB] FAIL ovf[%0d] sel: got %0d expected %0d", i, Next_Address_Select, st[i].sel);
            end
            sb.push_back(st[i]);
            @(posedge Clock); #1;
            e = sb.pop_front();
            checks++;
            if (State_Address !== e.addr) begin
                errors++; $display("[TB] FAIL ovf[%0d] addr: got %h expected %h", i, State_Address, e.addr);
            end
            checks++;
            if (Stack_Level !== e.lvl || Stack_Error !== e.err) begin
                errors++; $display("[TB] FAIL ovf[%0d] stack: got lvl=%0d err=%b expected lvl=%0d err=%b", i, Stack_Level, Stack_Error, e.lvl, e.err);
            end
        end
    endtask

    task automatic test_async_reset();
        step_t e;
        apply(mk(MSEQ_OP_ENC, 0, 0, 0, 8'h37, 0, 0, MSEQ_SRC_ENC, 8'h37, 0, STK));
        sb.push_back(mk(MSEQ_OP_ENC, 0, 0, 0, 8'h37, 0, 0, MSEQ_SRC_ENC, 8'h37, 0, STK));
        @(posedge Clock); #1;
        e = sb.pop_front();
        checks++;
        if (State_Address !== e.addr || Stack_Error !== e.err) begin
            errors++; $display("[TB] FAIL areset pre: got addr=%h err=%b expected addr=%h err=%b", State_Address, Stack_Error, e.addr, e.err);
        end
        #2 Reset_N = 1'b0;
        #1;
        checks++;
        if (State_Address !== 8'h00 || Stack_Level !== 3'd0 || Stack_Error !== 1'b0) begin
            errors++; $display("[TB] FAIL areset: got addr=%h lvl=%0d err=%b expected addr=00 lvl=0 err=0", State_Address, Stack_Level, Stack_Error);
        end
        @(negedge Clock);
        Reset_N = 1'b1;
    endtask

    task automatic test_stall();
        step_t st[$];
        step_t e;
        st.push_back(mk(MSEQ_OP_ENC,  0, 0, 0, 8'h10, 0,     0, MSEQ_SRC_ENC,    8'h10, 0, 0));
        st.push_back(mk(MSEQ_OP_CALL, 0, 0, 0, 0,     8'h80, 0, MSEQ_SRC_BRANCH, 8'h80, STK ? 3'd1 : 3'd0, 0));
        st.push_back(mk(MSEQ_OP_CALL, 0, 0, 0, 0,     8'h90, 1, MSEQ_SRC_BRANCH, 8'h80, STK ? 3'd1 : 3'd0, 0));
        st.push_back(mk(MSEQ_OP_RET,  0, 0, 0, 0,     8'h90, 1, STK ? MSEQ_SRC_POP : MSEQ_SRC_FETCH,
                        8'h80, STK ? 3'd1 : 3'd0, 0));
        st.push_back(mk(MSEQ_OP_RET,  0, 0, 0, 0,     8'h90, 0, STK ? MSEQ_SRC_POP : MSEQ_SRC_FETCH,
                        STK ? 8'h11 : 8'h01, 0, 0));
        st.push_back(mk(MSEQ_OP_INC,  0, 0, 0, 0,     8'h90, 1, MSEQ_SRC_INC, STK ? 8'h11 : 8'h01, 0, 0));
        st.push_back(mk(MSEQ_OP_INC,  0, 0, 0, 0,     8'h90, 0, MSEQ_SRC_INC, STK ? 8'h12 : 8'h02, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            checks++;
            if (Next_Address_Select !== st[i].sel) begin
                errors++; $display("[TB] FAIL stall[%0d] sel: got %0d expected %0d", i, Next_Address_Select, st[i].sel);
            end
            sb.push_back(st[i]);
            @(posedge Clock); #1;
            e = sb.pop_front();
            checks++;
            if (State_Address !== e.addr) begin
                errors++; $display("[TB] FAIL stall[%0d] addr: got %h expected %h", i, State_Address, e.addr);
            end
            checks++;
            if (Stack_Level !== e.lvl || Stack_Error !== e.err) begin
                errors++; $display("[TB] FAIL stall[%0d] stack: got lvl=%0d err=%b expected lvl=%0d err=%b", i, Stack_Level, Stack_Error, e.lvl, e.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequencing();
        test_wait();
        test_call_ret();
        test_overflow();
        test_async_reset();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
